// File: rtl/tx_inyector_if.sv
// Transmit injector bus: upstream stream, four FIFO push lanes, counter read port and status.
interface tx_inyector_if #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 5
);
    logic              init;
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic [3:0]        almost_full;
    logic [DATA_W-1:0] fifo0_i;
    logic [DATA_W-1:0] fifo1_i;
    logic [DATA_W-1:0] fifo2_i;
    logic [DATA_W-1:0] fifo3_i;
    logic              push0;
    logic              push1;
    logic              push2;
    logic              push3;
    logic              req;
    logic [1:0]        idx;
    logic [CNT_W-1:0]  count_out;
    logic              count_valid;
    logic              idle_out;
    logic              active_out;

    // Injector side.
    modport slave (
        input  init, data_in, valid_in, almost_full, req, idx,
        output ready_out, fifo0_i, fifo1_i, fifo2_i, fifo3_i,
               push0, push1, push2, push3, count_out, count_valid,
               idle_out, active_out
    );

    // Upstream / FIFO side.
    modport master (
        output init, data_in, valid_in, almost_full, req, idx,
        input  ready_out, fifo0_i, fifo1_i, fifo2_i, fifo3_i,
               push0, push1, push2, push3, count_out, count_valid,
               idle_out, active_out
    );
endinterface

// File: rtl/tx_inyector.sv
// Transmit-side packet injector: routes a single upstream word stream to four FIFO push
// lanes by destination bits, through a one-entry holding register, honouring per-lane
// almost-full back-pressure, and keeps per-lane sent-word counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RESET  | just left reset; outputs cleared, nothing accepted
// ST_INIT   | init sequence; counters held at 0, no accepts, no pushes
// ST_IDLE   | running, holding register empty, no traffic offered
// ST_ACTIVE | running, word held and/or words being offered
module tx_inyector #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic          clk,
    input  logic          reset,
    tx_inyector_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_hold_data;
    logic [1:0]        r_hold_dest;
    logic              r_hold_valid;

    logic [DATA_W-1:0] r_fifo [4];
    logic [3:0]        r_push;
    logic [CNT_W-1:0]  r_cnt  [4];
    logic [CNT_W-1:0]  r_count_out;
    logic              r_count_valid;
    logic              r_idle;
    logic              r_active;

    logic              w_run;
    logic              w_ready;
    logic              w_accept;
    logic              w_drain;
    logic              w_hold_valid_nxt;

    // Handshake decode and next-state selection.
    always_comb begin
        w_run            = ((r_state == ST_IDLE) || (r_state == ST_ACTIVE)) && !bus.init;
        w_ready          = w_run && (!r_hold_valid || !bus.almost_full[r_hold_dest]);
        w_accept         = bus.valid_in && w_ready;
        w_drain          = w_run && r_hold_valid && !bus.almost_full[r_hold_dest];
        // Leaving the running states (init) discards the held word.
        w_hold_valid_nxt = w_accept || (w_run && r_hold_valid && !w_drain);

        w_state_nxt = r_state;
        if ((r_state != ST_RESET) && bus.init) begin
            w_state_nxt = ST_INIT;
        end else begin
            case (r_state)
                ST_RESET:  w_state_nxt = ST_INIT;
                ST_INIT:   w_state_nxt = ST_IDLE;
                ST_IDLE:   if (bus.valid_in) w_state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (!w_hold_valid_nxt && !bus.valid_in) w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_RESET;
            endcase
        end
    end

    // FSM state register with registered status decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RESET;
            r_idle   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idle   <= (w_state_nxt == ST_IDLE);
            r_active <= (w_state_nxt == ST_ACTIVE);
        end
    end

    // Holding register and push lanes; a drain and an accept on the same edge keep full rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_data  <= '0;
            r_hold_dest  <= '0;
            r_hold_valid <= 1'b0;
            r_push       <= '0;
            for (int n = 0; n < 4; n++) r_fifo[n] <= '0;
        end else begin
            r_hold_valid <= w_hold_valid_nxt;
            if (w_accept) begin
                r_hold_data <= bus.data_in;
                r_hold_dest <= bus.data_in[DATA_W-1 -: 2];
            end
            r_push <= '0;
            if (w_drain) begin
                r_push[r_hold_dest] <= 1'b1;
                r_fifo[r_hold_dest] <= r_hold_data;
            end
        end
    end

    // Per-lane sent counters and the counter read port; reads see the pre-increment value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) r_cnt[n] <= '0;
            r_count_out   <= '0;
            r_count_valid <= 1'b0;
        end else begin
            if (bus.init || (r_state == ST_RESET) || (r_state == ST_INIT)) begin
                for (int n = 0; n < 4; n++) r_cnt[n] <= '0;
            end else if (w_drain) begin
                r_cnt[r_hold_dest] <= r_cnt[r_hold_dest] + 1'b1;
            end

            if (bus.req && (r_state != ST_RESET)) begin
                r_count_out   <= r_cnt[bus.idx];
                r_count_valid <= 1'b1;
            end else begin
                r_count_valid <= 1'b0;
            end
        end
    end

    assign bus.ready_out   = w_ready;
    assign bus.fifo0_i     = r_fifo[0];
    assign bus.fifo1_i     = r_fifo[1];
    assign bus.fifo2_i     = r_fifo[2];
    assign bus.fifo3_i     = r_fifo[3];
    assign bus.push0       = r_push[0];
    assign bus.push1       = r_push[1];
    assign bus.push2       = r_push[2];
    assign bus.push3       = r_push[3];
    assign bus.count_out   = r_count_out;
    assign bus.count_valid = r_count_valid;
    assign bus.idle_out    = r_idle;
    assign bus.active_out  = r_active;

endmodule

// File: tb/tb_tx_inyector.sv
// Self-checking bench for tx_inyector: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_tx_inyector;

    logic clk;
    logic reset;

    tx_inyector_if #(.DATA_W(10), .CNT_W(5)) bus ();

    tx_inyector #(.DATA_W(10), .CNT_W(5)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: phase 0 = reset, 1 = init, 2 = running.
    int         ph;
    logic [9:0] q [$];
    int         cnt [4];
    logic [9:0] efifo [4];
    logic [3:0] epush;
    logic [4:0] eco;
    logic       ecv;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        ph = 0;
        q.delete();
        for (int n = 0; n < 4; n++) begin
            cnt[n]   = 0;
            efifo[n] = '0;
        end
        epush = '0;
        eco   = '0;
        ecv   = 1'b0;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        logic       run;
        logic       exp_rdy;
        logic [9:0] head;
        int         lane;
        #1;
        run     = (ph == 2) && !bus.init;
        head    = (q.size() > 0) ? q[0] : 10'd0;
        exp_rdy = run && ((q.size() == 0) || !bus.almost_full[head[9:8]]);
        check_val("ready", bus.ready_out, exp_rdy);

        epush = '0;
        if (reset) begin
            model_clear();
        end else begin
            if ((ph != 0) && bus.req) begin
                eco = 5'(cnt[bus.idx]);
                ecv = 1'b1;
            end else begin
                ecv = 1'b0;
            end
            if (run && (q.size() > 0) && !bus.almost_full[head[9:8]]) begin
                lane        = int'(head[9:8]);
                epush[lane] = 1'b1;
                efifo[lane] = head;
                cnt[lane]   = (cnt[lane] + 1) % 32;
                void'(q.pop_front());
            end
            if (exp_rdy && bus.valid_in) q.push_back(bus.data_in);
            if (bus.init) q.delete();
            if (bus.init || (ph < 2)) begin
                for (int n = 0; n < 4; n++) cnt[n] = 0;
            end
            if (bus.init || (ph == 0)) ph = 1;
            else if (ph == 1)          ph = 2;
        end

        @(posedge clk);
        #1;
        check_val("push", {bus.push3, bus.push2, bus.push1, bus.push0}, epush);
        check_val("fifo_data", {bus.fifo3_i, bus.fifo2_i, bus.fifo1_i, bus.fifo0_i},
                  {efifo[3], efifo[2], efifo[1], efifo[0]});
        check_val("count_valid", bus.count_valid, ecv);
        check_val("count_out", bus.count_out, eco);
        check_val("idle_out", bus.idle_out, (ph == 2) && (q.size() == 0));
        check_val("active_out", bus.active_out, (ph == 2) && (q.size() != 0));
    endtask

    task automatic read_all();
        for (int i = 0; i < 4; i++) begin
            bus.req = 1'b1;
            bus.idx = 2'(i);
            tick();
        end
        bus.req = 1'b0;
        tick();
    endtask

    task automatic init_pulse();
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        tick();
    endtask

    logic [9:0] stream [5];

    initial begin
        reset           = 1'b1;
        bus.init        = 1'b0;
        bus.data_in     = '0;
        bus.valid_in    = 1'b0;
        bus.almost_full = '0;
        bus.req         = 1'b0;
        bus.idx         = '0;
        model_clear();
        @(posedge clk);
        #1;
        tick();

        // Reset release, init held for two cycles, then idle and read all counters.
        reset    = 1'b0;
        bus.init = 1'b1;
        tick();
        tick();
        bus.init = 1'b0;
        tick();
        read_all();

        // Back-to-back stream across all lanes.
        stream[0] = 10'h000; stream[1] = 10'h101; stream[2] = 10'h202;
        stream[3] = 10'h303; stream[4] = 10'h0AA;
        for (int i = 0; i < 5; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = stream[i];
            tick();
        end
        bus.valid_in = 1'b0;
        tick();
        tick();
        read_all();

        // Lane 2 back-pressure with a word for lane 0 waiting behind it.
        bus.almost_full = 4'b0100;
        bus.valid_in    = 1'b1;
        bus.data_in     = 10'h2F0;
        tick();
        bus.data_in = 10'h055;
        for (int i = 0; i < 5; i++) tick();
        bus.almost_full = 4'b0000;
        tick();
        bus.valid_in = 1'b0;
        tick();
        tick();

        // 33 words to lane 3: counter wraps to 1.
        init_pulse();
        for (int i = 0; i < 33; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = {2'b11, 8'($urandom)};
            tick();
        end
        bus.valid_in = 1'b0;
        tick();
        tick();
        bus.req = 1'b1;
        bus.idx = 2'd3;
        tick();
        bus.req = 1'b0;
        tick();
        tick();

        // Init while a word is held under back-pressure.
        bus.almost_full = 4'b0010;
        bus.valid_in    = 1'b1;
        bus.data_in     = 10'h1AB;
        tick();
        bus.valid_in = 1'b0;
        tick();
        tick();
        bus.init = 1'b1;
        tick();
        tick();
        bus.almost_full = 4'b0000;
        bus.init        = 1'b0;
        tick();
        tick();
        read_all();

        // Reset in the middle of a lane-1 stream.
        for (int i = 0; i < 3; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = {2'b01, 8'(i + 1)};
            tick();
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        bus.valid_in = 1'b0;
        tick();

        // Randomized traffic with occasional init and reset.
        for (int i = 0; i < 500; i++) begin
            bus.valid_in    = ($urandom % 4) != 0;
            bus.data_in     = 10'($urandom);
            bus.almost_full = 4'($urandom & $urandom);
            bus.req         = ($urandom % 3) == 0;
            bus.idx         = 2'($urandom);
            bus.init        = ($urandom % 50) == 0;
            reset           = ($urandom % 80) == 0;
            tick();
        end
        reset           = 1'b0;
        bus.init        = 1'b0;
        bus.valid_in    = 1'b0;
        bus.almost_full = '0;
        bus.req         = 1'b0;
        tick();
        tick();
        read_all();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
